// File: rtl/fp_mac_pkg.sv
// fp_mac_pkg: shared definitions for the FP multiply-accumulate stream engine
// and its normaliser.
//   fmt_bias()  - exponent bias for a given exponent width
//   fmt_acc_w() - width of the exact two's-complement accumulator
//   state_e     - control FSM states
//   ZERO_FILL / SAT_FILL - fill bits for the zero result and the
//                          saturated (max finite) result encodings
package fp_mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,  // accepting operand pairs
    DRAIN = 2'd1,  // waiting for the final element to reach stage 3
    HOLD  = 2'd2   // result presented, waiting for the consumer
  } state_e;

  // A zero result is every bit clear; a saturated result keeps the sign and
  // sets every exponent and mantissa bit.
  localparam logic ZERO_FILL = 1'b0;
  localparam logic SAT_FILL  = 1'b1;

  function automatic int fmt_bias(input int exp_w);
    return (2 ** (exp_w - 1)) - 1;
  endfunction

  // Largest product is (2^(MAN_W+1)-1)^2 shifted by 2*(2^EXP_W-1)-2, plus one
  // sign bit, plus headroom for MAX_LEN additions: the sum can never overflow.
  function automatic int fmt_acc_w(input int exp_w, input int man_w, input int max_len);
    return 2 * (man_w + 1) + 2 * ((2 ** exp_w) - 1) - 2 + 1 + $clog2(max_len);
  endfunction

endpackage

// File: rtl/fp_mac_stream_if.sv
// fp_mac_stream_if: operand input stream and result output stream of the
// FP MAC engine.
//   in_valid96/in_ready96   - operand pair handshake
//   in_a96/in_b96           - operands {sign, exp, man}
//   in_last96               - pair closes the vector
//   out_valid96/out_ready96 - result handshake
//   out_result96            - normalised FP result
//   out_sat96               - result clamped to max finite
//   out_count96             - elements accumulated into the result
// Modport slave is the engine side, master is the producer/consumer side.
interface fp_mac_stream_if #(
  parameter int EXP_W   = 3,
  parameter int MAN_W   = 4,
  parameter int MAX_LEN = 16
);
  localparam int FW    = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic             in_valid96;
  logic             in_ready96;
  logic [FW-1:0]    in_a96;
  logic [FW-1:0]    in_b96;
  logic             in_last96;
  logic             out_valid96;
  logic             out_ready96;
  logic [FW-1:0]    out_result96;
  logic             out_sat96;
  logic [CNT_W-1:0] out_count96;

  modport slave (
    input  in_valid96, in_a96, in_b96, in_last96, out_ready96,
    output in_ready96, out_valid96, out_result96, out_sat96, out_count96
  );

  modport master (
    output in_valid96, in_a96, in_b96, in_last96, out_ready96,
    input  in_ready96, out_valid96, out_result96, out_sat96, out_count96
  );

endinterface

// File: rtl/fp_acc_normalize.sv
// fp_acc_normalize: combinational conversion of the wide two's-complement
// accumulator into a normalised, saturated FP value.
//   acc_i    - accumulator, LSB weight 2^(2-2*BIAS-2*MAN_W)
//   result_o - {sign, exp, man}, mantissa truncated toward zero
//   sat_o    - magnitude exceeded the largest finite value
module fp_acc_normalize
  import fp_mac_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int ACC_W = 27
) (
  input  logic [ACC_W-1:0]         acc_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic                     sat_o
);

  localparam int FW   = 1 + EXP_W + MAN_W;
  localparam int BIAS = fmt_bias(EXP_W);
  localparam int EMAX = (2 ** EXP_W) - 1;

  logic             sign;
  logic [ACC_W-1:0] mag;
  int               lead;
  int               exp_i;
  logic [MAN_W-1:0] man;

  always_comb begin
    sign = acc_i[ACC_W-1];
    mag  = sign ? -acc_i : acc_i;

    // Leading-one position: the highest set bit wins.
    lead = 0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) lead = i;
    end

    // Mantissa = MAN_W bits directly below the leading one. Selecting by
    // comparing every bit position keeps all indices constant.
    man = '0;
    for (int j = 0; j < ACC_W; j++) begin
      for (int k = 0; k < MAN_W; k++) begin
        if (j == lead - 1 - k) man[MAN_W-1-k] = mag[j];
      end
    end

    exp_i = lead + 2 - BIAS - 2 * MAN_W;

    result_o = {FW{ZERO_FILL}};
    sat_o    = 1'b0;
    if (mag != '0 && exp_i >= 1) begin
      if (exp_i > EMAX) begin
        result_o = {sign, {(FW-1){SAT_FILL}}};
        sat_o    = 1'b1;
      end else begin
        result_o = {sign, exp_i[EXP_W-1:0], man};
      end
    end
  end

endmodule

// File: rtl/fp_mac_stream.sv
// fp_mac_stream: pipelined FP multiply-accumulate over a valid/ready stream.
//   clk96   - clock, rising edge
//   rst_n96 - asynchronous active-low reset
//   bus     - operand input / result output streams (slave side)
// Pipeline: stage 1 multiplies the mantissas and forms the shift, stage 2
// adds the shifted signed product into an exact accumulator, stage 3
// registers the normalised result. The FSM then loads the output registers,
// so a last element accepted at edge T shows out_valid96 after edge T+3.
module fp_mac_stream
  import fp_mac_pkg::*;
#(
  parameter int EXP_W   = 3,
  parameter int MAN_W   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic           clk96,
  input  logic           rst_n96,
  fp_mac_stream_if.slave bus
);

  localparam int FW     = 1 + EXP_W + MAN_W;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int ACC_W  = fmt_acc_w(EXP_W, MAN_W, MAX_LEN);
  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int SH_W   = EXP_W + 1;

  // Control
  state_e state_q, state_d;
  logic   in_ready, in_fire, out_fire, vec_end;

  // Stage 1: product
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic              s1_sign_q, s1_sign_d;
  logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic [SH_W-1:0]   s1_shift_q, s1_shift_d;

  // Stage 2: accumulator
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  term;
  logic              s2_last_q, s2_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Stage 3: normalised result
  logic              s3_valid_q, s3_valid_d;
  logic [FW-1:0]     s3_result_q, s3_result_d;
  logic              s3_sat_q, s3_sat_d;
  logic [FW-1:0]     norm_result;
  logic              norm_sat;

  // Output registers
  logic              out_valid_q, out_valid_d;
  logic [FW-1:0]     out_result_q, out_result_d;
  logic              out_sat_q, out_sat_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  ma, mb;

  assign ea = bus.in_a96[FW-2 -: EXP_W];
  assign eb = bus.in_b96[FW-2 -: EXP_W];
  assign ma = bus.in_a96[MAN_W-1:0];
  assign mb = bus.in_b96[MAN_W-1:0];

  assign in_ready = (state_q == ACCUM);
  assign in_fire  = bus.in_valid96 && in_ready;
  assign out_fire = out_valid_q && bus.out_ready96;
  // The MAX_LEN-th element closes the vector even without in_last96.
  assign vec_end  = in_fire && (bus.in_last96 || cnt_q == CNT_W'(MAX_LEN - 1));

  // Stage 1
  always_comb begin
    s1_valid_d = in_fire;
    s1_last_d  = vec_end;
    s1_sign_d  = s1_sign_q;
    s1_prod_d  = s1_prod_q;
    s1_shift_d = s1_shift_q;
    if (in_fire) begin
      s1_sign_d  = bus.in_a96[FW-1] ^ bus.in_b96[FW-1];
      // Exponent 0 encodes zero regardless of the mantissa bits.
      s1_prod_d  = (ea == '0 || eb == '0) ? '0
                 : PROD_W'({1'b1, ma}) * PROD_W'({1'b1, mb});
      // Wraps for a zero exponent, but the product is zero then.
      s1_shift_d = SH_W'(ea) + SH_W'(eb) - SH_W'(2);
    end
  end

  // Stage 2 and element counter
  always_comb begin
    term = ACC_W'(s1_prod_q) << s1_shift_q;
    if (s1_sign_q) term = -term;

    acc_d = acc_q;
    if (s1_valid_q) acc_d = acc_q + term;
    // No element can be in flight in HOLD, so clearing here loses nothing.
    if (out_fire) acc_d = '0;

    s2_last_d = s1_valid_q && s1_last_q;

    cnt_d = cnt_q;
    if (in_fire)  cnt_d = cnt_q + CNT_W'(1);
    if (out_fire) cnt_d = '0;
  end

  fp_acc_normalize #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .ACC_W (ACC_W)
  ) u_norm (
    .acc_i    (acc_q),
    .result_o (norm_result),
    .sat_o    (norm_sat)
  );

  // Stage 3: sampled the cycle after the final add has landed in acc_q.
  always_comb begin
    s3_valid_d  = s2_last_q;
    s3_result_d = s3_result_q;
    s3_sat_d    = s3_sat_q;
    if (s2_last_q) begin
      s3_result_d = norm_result;
      s3_sat_d    = norm_sat;
    end
  end

  // Control FSM: next state and output registers
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_sat_d    = out_sat_q;
    out_count_d  = out_count_q;
    case (state_q)
      ACCUM: begin
        if (vec_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (s3_valid_q) begin
          out_valid_d  = 1'b1;
          out_result_d = s3_result_q;
          out_sat_d    = s3_sat_q;
          out_count_d  = cnt_q;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready96) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk96 or negedge rst_n96) begin
    if (!rst_n96) begin
      state_q      <= ACCUM;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_prod_q    <= '0;
      s1_shift_q   <= '0;
      acc_q        <= '0;
      s2_last_q    <= 1'b0;
      cnt_q        <= '0;
      s3_valid_q   <= 1'b0;
      s3_result_q  <= '0;
      s3_sat_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_sign_q    <= s1_sign_d;
      s1_prod_q    <= s1_prod_d;
      s1_shift_q   <= s1_shift_d;
      acc_q        <= acc_d;
      s2_last_q    <= s2_last_d;
      cnt_q        <= cnt_d;
      s3_valid_q   <= s3_valid_d;
      s3_result_q  <= s3_result_d;
      s3_sat_q     <= s3_sat_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_sat_q    <= out_sat_d;
      out_count_q  <= out_count_d;
    end
  end

  assign bus.in_ready96   = in_ready;
  assign bus.out_valid96  = out_valid_q;
  assign bus.out_result96 = out_result_q;
  assign bus.out_sat96    = out_sat_q;
  assign bus.out_count96  = out_count_q;

endmodule

// File: tb/tb_fp_mac_stream.sv
// tb_fp_mac_stream: directed and randomised vectors for fp_mac_stream,
// checked against a real-valued reference of the number format.
module tb_fp_mac_stream;

  localparam int EXP_W   = 3;
  localparam int MAN_W   = 4;
  localparam int MAX_LEN = 16;

  logic clk96   = 1'b0;
  logic rst_n96 = 1'b0;

  always #5 clk96 = ~clk96;

  fp_mac_stream_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MAX_LEN(MAX_LEN)) bus ();

  fp_mac_stream #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MAX_LEN(MAX_LEN)) dut (
    .clk96   (clk96),
    .rst_n96 (rst_n96),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] va [MAX_LEN];
  logic [7:0] vb [MAX_LEN];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Real value of an operand: exponent 0 is zero, otherwise (1+m/16)*2^(e-3).
  function automatic real fp_val(input logic [7:0] x);
    real v;
    int  e;
    e = int'(x[6:4]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(int'(x[3:0])) / 16.0;
    for (int i = 0; i < e - 3; i++) v = v * 2.0;
    for (int i = 0; i < 3 - e; i++) v = v / 2.0;
    return x[7] ? -v : v;
  endfunction

  // Encode an exact sum: {sat, result}. Truncate toward zero, flush small
  // values to +0, clamp large ones to max finite.
  function automatic logic [8:0] fp_enc(input real s);
    real  mag;
    int   e;
    int   man;
    logic sgn;
    if (s == 0.0) return 9'h000;
    sgn = (s < 0.0);
    mag = sgn ? -s : s;
    e = 0;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0)  begin mag = mag * 2.0; e--; end
    e = e + 3;
    if (e < 1) return 9'h000;
    if (e > 7) return {1'b1, sgn, 7'h7F};
    man = int'($floor((mag - 1.0) * 16.0));
    return {1'b0, sgn, e[2:0], man[3:0]};
  endfunction

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {1'($urandom), 3'($urandom_range(0, 5)), 4'($urandom)};
  endfunction

  // Present one pair (after a random bubble) and return at the negedge
  // following the accepting edge.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int k;
    repeat ($urandom_range(0, 2)) @(negedge clk96);
    bus.in_valid96 = 1'b1;
    bus.in_a96     = a;
    bus.in_b96     = b;
    bus.in_last96  = last;
    k = 0;
    while (!bus.in_ready96 && k < 50) begin
      @(negedge clk96);
      k++;
    end
    if (k >= 50) check_val("in_ready_timeout", 32'(bus.in_ready96), 32'd1);
    @(posedge clk96);
    @(negedge clk96);
    bus.in_valid96 = 1'b0;
    bus.in_last96  = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!bus.out_valid96 && k < 50) begin
      @(negedge clk96);
      k++;
    end
  endtask

  // Send va/vb[0..n-1], check latency, result and backpressure behaviour.
  // want < 0 means take the expectation from the reference model.
  task automatic run_vec(input int n, input bit mark_last, input int hold,
                         input string name, input int want);
    real        sum;
    logic [8:0] exp_v;
    int         k;
    sum = 0.0;
    for (int i = 0; i < n; i++) sum = sum + fp_val(va[i]) * fp_val(vb[i]);
    exp_v = (want < 0) ? fp_enc(sum) : want[8:0];
    for (int i = 0; i < n; i++) send_pair(va[i], vb[i], mark_last && (i == n - 1));
    check_val({name, "_in_ready_drop"}, 32'(bus.in_ready96), 32'd0);
    wait_out(k);
    check_val({name, "_latency"}, 32'(k), 32'd3);
    check_val({name, "_result"}, 32'(bus.out_result96), 32'(exp_v[7:0]));
    check_val({name, "_sat"}, 32'(bus.out_sat96), 32'(exp_v[8]));
    check_val({name, "_count"}, 32'(bus.out_count96), 32'(n));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk96);
      check_val({name, "_hold_valid"}, 32'(bus.out_valid96), 32'd1);
      check_val({name, "_hold_result"}, 32'(bus.out_result96), 32'(exp_v[7:0]));
      check_val({name, "_hold_in_ready"}, 32'(bus.in_ready96), 32'd0);
    end
    bus.out_ready96 = 1'b1;
    @(posedge clk96);
    @(negedge clk96);
    bus.out_ready96 = 1'b0;
    check_val({name, "_ack_valid"}, 32'(bus.out_valid96), 32'd0);
    check_val({name, "_ack_in_ready"}, 32'(bus.in_ready96), 32'd1);
    $display("vec %s len=%0d last=%0b exp=0x%02h sat=%0b", name, n, mark_last,
             exp_v[7:0], exp_v[8]);
  endtask

  task automatic check_reset_state(input string name);
    check_val({name, "_in_ready"}, 32'(bus.in_ready96), 32'd1);
    check_val({name, "_out_valid"}, 32'(bus.out_valid96), 32'd0);
    check_val({name, "_out_result"}, 32'(bus.out_result96), 32'd0);
    check_val({name, "_out_sat"}, 32'(bus.out_sat96), 32'd0);
    check_val({name, "_out_count"}, 32'(bus.out_count96), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.in_valid96  = 1'b0;
    bus.in_a96      = '0;
    bus.in_b96      = '0;
    bus.in_last96   = 1'b0;
    bus.out_ready96 = 1'b0;

    #12;
    check_reset_state("reset");
    @(negedge clk96);
    rst_n96 = 1'b1;

    va[0] = 8'h30; vb[0] = 8'h30;
    run_vec(1, 1'b1, 0, "single", 'h030);

    va[0] = 8'h38; vb[0] = 8'h40; va[1] = 8'h30; vb[1] = 8'hB0;
    run_vec(2, 1'b1, 1, "mixed", 'h040);

    va[0] = 8'h30; vb[0] = 8'h30; va[1] = 8'hB0; vb[1] = 8'h30;
    run_vec(2, 1'b1, 0, "cancel", 'h000);

    va[0] = 8'h05; vb[0] = 8'h7F;
    run_vec(1, 1'b1, 0, "zero_exp", 'h000);

    va[0] = 8'h7F; vb[0] = 8'h7F;
    run_vec(1, 1'b1, 0, "saturate", 'h17F);

    va[0] = 8'h10; vb[0] = 8'h10;
    run_vec(1, 1'b1, 0, "underflow", 'h000);

    va[0] = 8'h30; vb[0] = 8'h40;
    run_vec(1, 1'b1, 5, "backpressure", 'h040);

    for (int i = 0; i < MAX_LEN; i++) begin va[i] = 8'h30; vb[i] = 8'h30; end
    run_vec(MAX_LEN, 1'b0, 0, "forced_last", 'h070);

    // Reset while a saturated result is held.
    send_pair(8'h7F, 8'h7F, 1'b1);
    wait_out(k);
    check_val("rst_hold_pre_valid", 32'(bus.out_valid96), 32'd1);
    rst_n96 = 1'b0;
    #1;
    check_reset_state("rst_hold");
    @(negedge clk96);
    rst_n96 = 1'b1;

    // Reset mid-vector; the next vector must start from an empty accumulator.
    send_pair(8'h40, 8'h40, 1'b0);
    send_pair(8'h40, 8'h40, 1'b0);
    rst_n96 = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk96);
    rst_n96 = 1'b1;
    va[0] = 8'h30; vb[0] = 8'h30;
    run_vec(1, 1'b1, 0, "after_rst", 'h030);

    for (int v = 0; v < 40; v++) begin
      int  n;
      bit  mark;
      n    = int'($urandom_range(1, MAX_LEN));
      mark = (n < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        va[i] = rand_op();
        vb[i] = rand_op();
      end
      run_vec(n, mark, int'($urandom_range(0, 3)), "rand", -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
